// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : vga_timing_pkg                                             |
// | Brief   : Default 640x480@60 Hz VGA timing constants, derived totals |
// |           and sync window bounds, and the shared coordinate type.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_SYNC_DELAY = 1;
  localparam int DEF_FRAME_W    = 16;

  localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  // Raster coordinate: wide enough for both H_TOTAL-1 and V_TOTAL-1.
  typedef logic [9:0] coord_t;

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/sync_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sync_delay_line                                            |
// | Brief   : Parametric-depth shift register for active-low syncs.      |
// |           Every stage resets to 1 so syncs stay inactive in reset.   |
// |           DEPTH = 0 is a straight wire.                              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module sync_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 1
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    // Clock and reset have no load in the zero-depth build.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = vga_clk ^ reset_n;
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift the syncs one stage per pixel clock; reset loads all-ones.
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= '1;
      end else begin
        r_stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign q = r_stage[DEPTH-1];
  end

endmodule : sync_delay_line
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : vga_timing_gen                                             |
// | Brief   : VGA raster timing generator. Free-running h/v counters     |
// |           feed one register stage of coordinates, blank and pulses;  |
// |           the syncs get SYNC_DELAY extra stages so they line up with |
// |           the renderers' registered RGB.                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int SYNC_DELAY = DEF_SYNC_DELAY,
  parameter int FRAME_W    = DEF_FRAME_W
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  output coord_t             DrawX,
  output coord_t             DrawY,
  output logic               blank,
  output logic               hs,
  output logic               vs,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam coord_t C_H_LAST       = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t C_V_LAST       = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t C_H_ACTIVE     = coord_t'(H_ACTIVE);
  localparam coord_t C_V_ACTIVE     = coord_t'(V_ACTIVE);
  localparam coord_t C_H_SYNC_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t C_H_SYNC_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t C_V_SYNC_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t C_V_SYNC_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  coord_t r_hc;
  coord_t r_vc;
  logic   r_hs_raw;
  logic   r_vs_raw;

  // Raster counters: hc every cycle, vc once per line wrap.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (r_hc == C_H_LAST) begin
      r_hc <= '0;
      r_vc <= (r_vc == C_V_LAST) ? '0 : r_vc + coord_t'(1);
    end else begin
      r_hc <= r_hc + coord_t'(1);
    end
  end

  // Stage 1: coordinates, visible flag, pulses and raw active-low syncs.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= '0;
      DrawY       <= '0;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      r_hs_raw    <= 1'b1;
      r_vs_raw    <= 1'b1;
    end else begin
      DrawX       <= r_hc;
      DrawY       <= r_vc;
      blank       <= (r_hc < C_H_ACTIVE) && (r_vc < C_V_ACTIVE);
      line_start  <= (r_hc == '0);
      frame_start <= (r_hc == '0) && (r_vc == '0);
      r_hs_raw    <= !((r_hc >= C_H_SYNC_START) && (r_hc <= C_H_SYNC_END));
      r_vs_raw    <= !((r_vc >= C_V_SYNC_START) && (r_vc <= C_V_SYNC_END));
    end
  end

  // Count frame starts; wraps naturally at 2^FRAME_W.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (frame_start) begin
      frame_count <= frame_count + FRAME_W'(1);
    end
  end

  sync_delay_line #(
    .WIDTH (2),
    .DEPTH (SYNC_DELAY)
  ) u_sync_delay (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .d       ({r_hs_raw, r_vs_raw}),
    .q       ({hs, vs})
  );

endmodule : vga_timing_gen
`default_nettype wire
